// File: rtl/reg_bank_pkg.sv
// Shared helpers for the reg_bank register store: LOCK address, byte-strobe merge, parity.
// Helpers take MAX_W-wide operands; callers size-cast in and out.
package reg_bank_pkg;

   localparam int unsigned MAX_W      = 256;
   localparam int unsigned MAX_STRB_W = MAX_W / 8;

   function automatic int unsigned lock_addr(input int unsigned num_regs);
      return num_regs;
   endfunction

   function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0]      old_v,
                                                   input logic [MAX_W-1:0]      new_v,
                                                   input logic [MAX_STRB_W-1:0] strb);
      logic [MAX_W-1:0] m;
      m = old_v;
      for (int unsigned b = 0; b < MAX_STRB_W; b++) begin
         if (strb[b]) m[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return m;
   endfunction

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_par(input logic [MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/reg_bank_word.sv
// One reg_bank storage word: strobe merge and lock gating.
// Optional parity store/check under REG_BANK_PARITY_EN.
module reg_bank_word
   import reg_bank_pkg::*;
#(
   parameter int unsigned       DATA_W  = 16,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  we_i,
   input  logic                  lock_i,
   input  logic [DATA_W/8-1:0]   wstrb_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     data_o,
   output logic                  par_bad_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              upd;

   always_comb begin
      upd    = we_i && !lock_i;
      data_d = DATA_W'(strb_merge(MAX_W'(data_q), MAX_W'(wdata_i), MAX_STRB_W'(wstrb_i)));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)    data_q <= RST_VAL;
      else if (upd) data_q <= data_d;
   end

   assign data_o = data_q;

`ifdef REG_BANK_PARITY_EN
   logic par_q;

   // Parity covers the merged word, so partial-strobe writes stay consistent.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)    par_q <= even_par(MAX_W'(RST_VAL));
      else if (upd) par_q <= even_par(MAX_W'(data_d));
   end

   assign par_bad_o = even_par(MAX_W'(data_q)) ^ par_q;
`else
   assign par_bad_o = 1'b0;
`endif

endmodule

// File: rtl/reg_bank.sv
// Addressed bank of NUM_REGS strobed data registers plus a sticky LOCK register,
// with a one-cycle registered ack/err response. Optional parity: REG_BANK_PARITY_EN.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int unsigned         DATA_W   = 16,
   parameter int unsigned         NUM_REGS = 8,
   localparam int unsigned        ADDR_W   = $clog2(NUM_REGS + 1),
   parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  sel,
   input  logic                  wr,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ack,
   output logic                  err,
   output logic [NUM_REGS-1:0]   lock_q
`ifdef REG_BANK_PARITY_EN
   ,
   output logic                  par_err_o
`endif
);

   localparam logic [ADDR_W-1:0] LOCK_A = ADDR_W'(lock_addr(NUM_REGS));

   logic [DATA_W-1:0]   word_q [NUM_REGS];
   logic [NUM_REGS-1:0] par_bad;
   logic [NUM_REGS-1:0] lock_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d, rd_val;
   logic                ack_q, ack_d, err_q, err_d;
   logic                is_data, is_lock, is_oor, lk_sel, pb_sel;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
      reg_bank_word #(
         .DATA_W  (DATA_W),
         .RST_VAL (RST_VAL)
      ) u_word (
         .clk       (clk),
         .rstn      (rstn),
         .we_i      (sel && wr && (addr == ADDR_W'(i))),
         .lock_i    (lock_q[i]),
         .wstrb_i   (wstrb),
         .wdata_i   (wdata),
         .data_o    (word_q[i]),
         .par_bad_o (par_bad[i])
      );
   end

   always_comb begin
      is_data = addr < LOCK_A;
      is_lock = addr == LOCK_A;
      is_oor  = !is_data && !is_lock;
      rd_val  = '0;
      lk_sel  = 1'b0;
      pb_sel  = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (addr == ADDR_W'(i)) begin
            rd_val = word_q[i];
            lk_sel = lock_q[i];
            pb_sel = par_bad[i];
         end
      end
      if (is_lock) rd_val = DATA_W'(lock_q);

      lock_d = lock_q;
      if (sel && wr && is_lock) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            lock_d[k] = lock_q[k] | (wdata[k] & wstrb[k/8]);
         end
      end

      ack_d   = sel;
      err_d   = sel && (is_oor || (wr && is_data && lk_sel) || (!wr && is_data && pb_sel));
      rdata_d = (sel && !wr && !is_oor) ? rd_val : '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         lock_q  <= lock_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;

`ifdef REG_BANK_PARITY_EN
   logic par_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) par_err_q <= 1'b0;
      else       par_err_q <= par_err_q | (sel && !wr && is_data && pb_sel);
   end

   assign par_err_o = par_err_q;
`endif

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised successor to the team's single 16-bit sel/wr register: an addressed bank of NUM_REGS read/write data registers.
- Adds per-byte write strobes, a registered read path with an ack/err handshake, and a sticky per-register write-lock register.
- Sits behind a simple peripheral select/write bus as the generic control/status store for a block.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- NUM_REGS, 8, number of data registers; must satisfy 1 <= NUM_REGS <= DATA_W.
- ADDR_W, $clog2(NUM_REGS+1), address width (derived; do not override).
- RST_VAL, 0, reset value of every data register.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- sel, input, 1, access request this cycle.
- wr, input, 1, 1 = write, 0 = read; qualified by sel.
- addr, input, ADDR_W, word address.
- wstrb, input, DATA_W/8, byte write enables; qualified by sel&wr.
- wdata, input, DATA_W, write data.
- rdata, output, DATA_W, read data; valid only while ack&~wr_q.
- ack, output, 1, one-cycle pulse one cycle after every accepted access.
- err, output, 1, qualifies ack; 1 = access rejected.
- lock_q, output, NUM_REGS, current lock bits.

Behaviour:
- Reset (async, rstn=0): all data registers = RST_VAL; lock_q=0; rdata=0, ack=0, err=0. Reset asserted mid-access aborts the access; no ack is issued for it.
- Address map:
  - 0..NUM_REGS-1: data registers.
  - NUM_REGS: LOCK register; bits [NUM_REGS-1:0] are lock bits, upper bits read 0.
  - Any address above NUM_REGS is out of range.
- Every cycle with sel=1 is an accepted access. Back-to-back accesses are allowed, one per cycle; there are no wait states.
- Write to data reg i:
  - If lock_q[i]=0: bytes with wstrb[b]=1 are updated at that edge, other bytes hold; ack=1, err=0 next cycle.
  - If lock_q[i]=1: no change; ack=1, err=1 next cycle.
- Write to LOCK: lock_q <= lock_q | wdata[NUM_REGS-1:0], using byte strobes. Bits are sticky: writing 0 never clears them; only reset clears them. err=0.
- Write to an out-of-range address: no state change; ack=1, err=1.
- Read:
  - Data and LOCK are sampled at the request edge; rdata presents them the next cycle with ack=1, err=0.
  - Out-of-range read: rdata=0, ack=1, err=1.
- rdata=0 in every cycle that is not a read ack.
- Latency: 1 cycle for reads and write acks.
- Read the cycle after a write to the same address returns the new value.
- wstrb=0 write: no change, normal ack, err=0.

Optional Feature:
- Macro: REG_BANK_PARITY_EN.
- With the macro defined:
  - Each data register stores one even-parity bit over DATA_W, computed on every write, including partial-strobe writes (over the merged value).
  - On a read, a mismatch sets err=1 alongside ack and still returns the stored data.
  - Extra output par_err_o (1 bit) is a sticky flag, cleared only by reset.
- Without the macro: no parity storage and no par_err_o port; err is only set for locked or out-of-range accesses.

Decomposition:
- Package reg_bank_pkg:
  - Function lock_addr(NUM_REGS).
  - Byte-strobe merge function: old, new, strb -> merged.
  - Even-parity function.
  - Localparam STRB_W = DATA_W/8.
- Sub-module reg_bank_word:
  - One storage word with strobe merge, lock gating and (under REG_BANK_PARITY_EN) parity store/check.
  - Instantiated NUM_REGS times by generate.
  - Top level holds the address decode, LOCK register and the registered response stage.

Test Plan:
- Reset with defaults (DATA_W=16, NUM_REGS=8): read addrs 0..8 -> rdata=0, ack=1, err=0 each, one cycle after each request.
- Write addr 3, wdata 0xA5C3, wstrb 2'b01, then read addr 3 -> rdata 0x00C3; write wstrb 2'b10 wdata 0x1200, read -> 0x12C3.
- Write LOCK with 0x0008; write addr 3 with 0xFFFF -> ack=1, err=1, read still 0x12C3; write LOCK with 0x0000 -> lock_q stays 0x08.
- Access addr 9 (read, then write): rdata=0, ack=1, err=1 for both, no register changes.
- Back-to-back write addr 1 = 0xBEEF then read addr 1 on the next cycle -> read ack returns 0xBEEF; assert rstn=0 during a read request -> no ack, all outputs 0, lock_q=0.
- With REG_BANK_PARITY_EN: force-flip a stored bit of reg 2 and read -> err=1, par_err_o=1 and held until reset.
